// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// ---------
// Pointer/flag controller for a first-word-fall-through FIFO. The storage
// array lives outside this block. It is written synchronously through
// w_en/w_addr and read asynchronously at r_addr, so the head word is always
// visible at r_addr.
//
// The pointers are ADDR_WIDTH+1 bits wide. The extra MSB tells full apart
// from empty when the low bits are equal. All status flags are derived from
// the registered pointers, so none of them has a combinational path from
// wr or rd.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr           in   push request (write data already on the storage bus)
//   rd           in   pop request (head word already on the storage bus)
//   clr          in   synchronous flush, overrides wr/rd
//   w_en         out  storage write strobe (combinational)
//   w_addr       out  storage write address
//   r_addr       out  storage read address (head of queue)
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  stored words, 0..DEPTH
//   overflow     out  sticky, a push was rejected
//   underflow    out  sticky, a pop was rejected
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                push_ok;
  logic                pop_ok;

  assign w_addr = wptr[ADDR_WIDTH-1:0];
  assign r_addr = rptr[ADDR_WIDTH-1:0];

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  // The modular difference of the pointers is exactly the occupancy,
  // including DEPTH when full, because the pointers carry one extra bit.
  assign count = wptr - rptr;

  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  // A push into a full FIFO is still accepted when a pop happens in the same
  // cycle: the write lands in the slot being vacated. A simultaneous pop is
  // always accepted when full, because full implies not empty.
  assign push_ok = wr && !clr && (!full || rd);
  assign pop_ok  = rd && !clr && !empty;

  // Gating with rst_n keeps the storage from being written while in reset.
  assign w_en = push_ok && rst_n;

  // Plain +1 on the extended pointer wraps the low bits from DEPTH-1 to 0
  // and toggles the MSB. No other modulo logic is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      if (wr && !push_ok) overflow  <= 1'b1;
      if (rd && empty)    underflow <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, address width of the storage array; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter AF_LEVEL, default 6, almost_full asserts when count >= AF_LEVEL.
REQ-003 Parameter AE_LEVEL, default 1, almost_empty asserts when count <= AE_LEVEL.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr  input  1  push request; data is on the storage write-data bus in the same cycle.
REQ-007 rd  input  1  pop request; head word is on the storage read-data bus in the same cycle.
REQ-008 clr  input  1  synchronous flush.
REQ-009 w_en  output  1  write strobe to the storage array.
REQ-010 w_addr  output  ADDR_WIDTH  write address to the storage array.
REQ-011 r_addr  output  ADDR_WIDTH  read address to the storage array (head of queue).
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_LEVEL.
REQ-015 almost_empty  output  1  count <= AE_LEVEL.
REQ-016 count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
REQ-017 overflow  output  1  sticky: a push was rejected.
REQ-018 underflow  output  1  sticky: a pop was rejected.

Function
REQ-019 Write and read pointers SHALL each be ADDR_WIDTH+1 bits; w_addr/r_addr are their low ADDR_WIDTH bits; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0 in the low bits and toggle the MSB on wrap; no other modulo logic.
REQ-021 A push is accepted when wr=1 and (full=0 or rd=1); an accepted push SHALL drive w_en=1 combinationally and advance the write pointer by 1 at the edge.
REQ-022 A pop is accepted when rd=1 and empty=0; it SHALL advance the read pointer by 1 at the edge; the storage is read asynchronously, so the popped word is the one on r_addr during the rd cycle (zero read latency, first-word fall-through).
REQ-023 wr=1, rd=1, 0<count<DEPTH: both accepted, count unchanged.
REQ-024 wr=1, rd=1, full=1: both accepted; write lands in the slot being vacated; count stays DEPTH.
REQ-025 wr=1, rd=1, empty=1: push accepted, pop rejected, underflow set; count becomes 1.
REQ-026 wr=1, full=1, rd=0: push rejected, w_en=0, overflow set, state otherwise unchanged.
REQ-027 rd=1, empty=1, wr=0: pop rejected, underflow set, state otherwise unchanged.
REQ-028 count, full, empty, almost_full, almost_empty SHALL be registered or derived from registered pointers only: no combinational path from wr/rd to these outputs.
REQ-029 w_en is the only output with a combinational dependency on wr, rd, clr.
REQ-030 clr=1 SHALL override wr/rd: w_en=0, both pointers to 0, overflow and underflow cleared at the edge.
REQ-031 overflow/underflow SHALL stay set until clr or reset.

Reset
REQ-032 rst_n=0 SHALL asynchronously force pointers to 0, count=0, empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0, overflow=0, underflow=0, w_addr=0, r_addr=0.
REQ-033 While rst_n=0, w_en SHALL be 0 regardless of wr.
REQ-034 Reset asserted mid-operation discards all queued words; first push after release writes address 0.

Verification
REQ-035 Reset, then 8 pushes (data 0x10..0x17), no pops -> w_addr 0..7 in order, full=1 after 8th edge, count=8, almost_full=1 from count 6.
REQ-036 Full, wr=1 rd=0 -> w_en=0, overflow=1 next cycle, count stays 8; then 8 pops -> read data 0x10..0x17 in order, empty=1, count=0.
REQ-037 Empty, wr=1 rd=1 with data 0xA5 -> underflow=1, count=1, r_addr=0 shows 0xA5 next cycle.
REQ-038 Full, wr=1 rd=1 for 12 cycles -> count stays 8, pointers wrap past 7 to 0, output stream in exact push order, no overflow.
REQ-039 count=5, clr=1 with wr=1 -> w_en=0, count=0, empty=1, sticky flags cleared; rst_n pulsed low mid-burst between edges -> outputs reach reset values immediately, without waiting for an edge.
